sc_tx_port_fifo: RTL and testbench

- Transmit-port buffer directly downstream of the slave-controller TX port arbiter.
- Accepts {cntl, data} byte pairs written by whichever client (sendPacket or directCntl) holds the grant, and drives the port ready back to the arbiter.
- Presents buffered pairs first-word-fall-through to the serial interface engine transmitter, using a valid/ack handshake.
- Decouples bursty arbiter writes from SIE byte-rate consumption.

---
 rtl/sc_tx_port_fifo.sv | 103 ++++++++++
 tb/tb_sc_tx_port_fifo.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_tx_port_fifo.sv
// TX port buffer between the slave-controller arbiter and the SIE transmitter.
// Define SC_TX_PORT_FIFO_OVF_DETECT_EN to add sticky dropped-write detection.
module sc_tx_port_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  txWEn,
    input  logic [7:0]            txData,
    input  logic [7:0]            txCntl,
    output logic                  txRdy,
    output logic [7:0]            sieData,
    output logic [7:0]            sieCntl,
    output logic                  sieValid,
    input  logic                  sieAck,
    input  logic                  flush,
    output logic [DEPTH_LOG2:0]   fifoCount
`ifdef SC_TX_PORT_FIFO_OVF_DETECT_EN
    ,
    output logic                  txOverflow,
    input  logic                  txOverflowClr
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [15:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push;
    logic                  pop;

    assign txRdy              = (count_q != FULL);
    assign sieValid           = (count_q != '0);
    assign {sieCntl, sieData} = mem_q[rdPtr_q];
    assign fifoCount          = count_q;

    assign push = txWEn && txRdy;
    assign pop  = sieAck && sieValid;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push)
                wrPtr_d = wrPtr_q + 1'b1;
            if (pop)
                rdPtr_d = rdPtr_q + 1'b1;
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Array is never reset; its contents only matter while sieValid is high.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem_q[wrPtr_q] <= {txCntl, txData};
    end

`ifdef SC_TX_PORT_FIFO_OVF_DETECT_EN
    logic ovf_q, ovf_d;

    // A new drop wins over a clear in the same cycle; flush leaves it alone.
    always_comb begin
        ovf_d = ovf_q;
        if (txWEn && !txRdy)
            ovf_d = 1'b1;
        else if (txOverflowClr)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_d;
    end

    assign txOverflow = ovf_q;
`endif

endmodule

// File: tb/tb_sc_tx_port_fifo.sv
// Randomized and directed bench for sc_tx_port_fifo against a queue model.
// Overflow checks compile only with SC_TX_PORT_FIFO_OVF_DETECT_EN.
module tb_sc_tx_port_fifo;

    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

    logic           clk = 1'b0;
    logic           rst;
    logic           txWEn;
    logic [7:0]     txData;
    logic [7:0]     txCntl;
    logic           txRdy;
    logic [7:0]     sieData;
    logic [7:0]     sieCntl;
    logic           sieValid;
    logic           sieAck;
    logic           flush;
    logic [DL2:0]   fifoCount;
`ifdef SC_TX_PORT_FIFO_OVF_DETECT_EN
    logic           txOverflow;
    logic           txOverflowClr = 1'b0;
    bit             ovf_m = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    logic [15:0] q[$];

    sc_tx_port_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk       (clk),
        .rst       (rst),
        .txWEn     (txWEn),
        .txData    (txData),
        .txCntl    (txCntl),
        .txRdy     (txRdy),
        .sieData   (sieData),
        .sieCntl   (sieCntl),
        .sieValid  (sieValid),
        .sieAck    (sieAck),
        .flush     (flush),
        .fifoCount (fifoCount)
`ifdef SC_TX_PORT_FIFO_OVF_DETECT_EN
        ,
        .txOverflow    (txOverflow),
        .txOverflowClr (txOverflowClr)
`endif
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, let the edge pass, then advance the model.
    task automatic cycle(input bit we, input logic [7:0] c,
                         input logic [7:0] d, input bit ack,
                         input bit fl);
        bit push, pop;
`ifdef SC_TX_PORT_FIFO_OVF_DETECT_EN
        bit clr;
        clr = txOverflowClr;
`endif
        txWEn  = we;
        txCntl = c;
        txData = d;
        sieAck = ack;
        flush  = fl;
        push = we && (q.size() < DEPTH);
        pop  = ack && (q.size() > 0);
        @(posedge clk);
        #1;
`ifdef SC_TX_PORT_FIFO_OVF_DETECT_EN
        if (we && q.size() == DEPTH)
            ovf_m = 1'b1;
        else if (clr)
            ovf_m = 1'b0;
`endif
        if (fl) begin
            q.delete();
        end else begin
            if (pop)
                void'(q.pop_front());
            if (push)
                q.push_back({c, d});
        end
        txWEn  = 1'b0;
        sieAck = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; txWEn = 0; sieAck = 0; flush = 0;
        txData = 0; txCntl = 0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (txRdy !== 1'b1 || sieValid !== 1'b0 || fifoCount !== 3'd0) begin
            bad++;
            $display("FAIL reset_idle: rdy=%b valid=%b cnt=%0d want 1 0 0",
                     txRdy, sieValid, fifoCount);
        end
        rst = 1'b0;
        cycle(1, 8'hC0, 8'h01, 0, 0);
        cycle(1, 8'hC1, 8'h02, 0, 0);
        total++;
        if (fifoCount !== 3'd2) begin
            bad++;
            $display("FAIL reset_prefill: cnt=%0d want 2", fifoCount);
        end
        #3 rst = 1'b1;
        #1;
        q.delete();
        total++;
        if (txRdy !== 1'b1 || sieValid !== 1'b0 || fifoCount !== 3'd0) begin
            bad++;
            $display("FAIL reset_async: rdy=%b valid=%b cnt=%0d want 1 0 0",
                     txRdy, sieValid, fifoCount);
        end
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        cycle(0, 8'h00, 8'h00, 1, 0);
        total++;
        if (fifoCount !== 3'd0 || sieValid !== 1'b0) begin
            bad++;
            $display("FAIL empty_ack: cnt=%0d valid=%b want 0 0",
                     fifoCount, sieValid);
        end
        cycle(1, 8'h01, 8'hA5, 0, 0);
        total++;
        if (sieValid !== 1'b1 || sieCntl !== 8'h01 || sieData !== 8'hA5 ||
            fifoCount !== 3'd1) begin
            bad++;
            $display("FAIL single_write: v=%b c=%h d=%h n=%0d want 1 01 a5 1",
                     sieValid, sieCntl, sieData, fifoCount);
        end
        cycle(0, 8'h00, 8'h00, 1, 0);
        total++;
        if (sieValid !== 1'b0 || fifoCount !== 3'd0) begin
            bad++;
            $display("FAIL single_pop: valid=%b cnt=%0d want 0 0",
                     sieValid, fifoCount);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++)
            cycle(1, 8'hF0 + 8'(i), 8'h10 + 8'(i), 0, 0);
        total++;
        if (fifoCount !== 3'd4 || txRdy !== 1'b0) begin
            bad++;
            $display("FAIL full_fill: cnt=%0d rdy=%b want 4 0",
                     fifoCount, txRdy);
        end
        cycle(1, 8'hF4, 8'h14, 0, 0);
        total++;
        if (fifoCount !== 3'd4) begin
            bad++;
            $display("FAIL full_drop: cnt=%0d want 4", fifoCount);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (sieValid !== 1'b1 || sieData !== 8'h10 + 8'(i) ||
                sieCntl !== 8'hF0 + 8'(i)) begin
                bad++;
                $display("FAIL full_drain%0d: v=%b c=%h d=%h want 1 %h %h",
                         i, sieValid, sieCntl, sieData,
                         8'hF0 + 8'(i), 8'h10 + 8'(i));
            end
            cycle(0, 8'h00, 8'h00, 1, 0);
        end
        total++;
        if (sieValid !== 1'b0 || fifoCount !== 3'd0) begin
            bad++;
            $display("FAIL full_empty: valid=%b cnt=%0d want 0 0",
                     sieValid, fifoCount);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_seq[$];
        exp_seq = '{8'h20, 8'h21, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        cycle(1, 8'h02, 8'h20, 0, 0);
        cycle(1, 8'h02, 8'h21, 0, 0);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (sieData !== exp_seq[i] || fifoCount !== 3'd2) begin
                bad++;
                $display("FAIL b2b_%0d: d=%h cnt=%0d want %h 2",
                         i, sieData, fifoCount, exp_seq[i]);
            end
            cycle(1, 8'h03, 8'h30 + 8'(i), 1, 0);
        end
        cycle(1, 8'h03, 8'h36, 0, 0);
        cycle(1, 8'h03, 8'h37, 0, 0);
        cycle(1, 8'h03, 8'h38, 1, 0);
        total++;
        if (fifoCount !== 3'd3 || sieData !== 8'h35) begin
            bad++;
            $display("FAIL full_push_pop: cnt=%0d d=%h want 3 35",
                     fifoCount, sieData);
        end
        cycle(0, 8'h00, 8'h00, 0, 1);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++)
            cycle(1, 8'h04, 8'h40 + 8'(i), 0, 0);
        cycle(1, 8'h04, 8'hEE, 0, 1);
        total++;
        if (fifoCount !== 3'd0 || sieValid !== 1'b0) begin
            bad++;
            $display("FAIL flush_clear: cnt=%0d valid=%b want 0 0",
                     fifoCount, sieValid);
        end
        cycle(1, 8'h05, 8'h55, 0, 0);
        total++;
        if (sieData !== 8'h55 || fifoCount !== 3'd1) begin
            bad++;
            $display("FAIL flush_after: d=%h cnt=%0d want 55 1",
                     sieData, fifoCount);
        end
        cycle(0, 8'h00, 8'h00, 0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 60, 8'($urandom), 8'($urandom),
                  $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
            total++;
            if (fifoCount !== 3'(q.size()) ||
                txRdy !== (q.size() != DEPTH) ||
                sieValid !== (q.size() != 0) ||
                (q.size() != 0 && {sieCntl, sieData} !== q[0])) begin
                bad++;
                $display("FAIL rand_%0d: n=%0d r=%b v=%b cd=%h want n=%0d",
                         i, fifoCount, txRdy, sieValid,
                         {sieCntl, sieData}, q.size());
            end
        end
        cycle(0, 8'h00, 8'h00, 0, 1);
    endtask

`ifdef SC_TX_PORT_FIFO_OVF_DETECT_EN
    task automatic test_overflow();
        for (int i = 0; i < 5; i++)
            cycle(1, 8'h06, 8'h60 + 8'(i), 0, 0);
        total++;
        if (txOverflow !== 1'b1 || ovf_m !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: got %b want 1", txOverflow);
        end
        cycle(0, 8'h00, 8'h00, 0, 1);
        total++;
        if (txOverflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flush: got %b want 1", txOverflow);
        end
        txOverflowClr = 1'b1;
        cycle(0, 8'h00, 8'h00, 0, 0);
        txOverflowClr = 1'b0;
        total++;
        if (txOverflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clr: got %b want 0", txOverflow);
        end
        for (int i = 0; i < 4; i++)
            cycle(1, 8'h07, 8'h70 + 8'(i), 0, 0);
        txOverflowClr = 1'b1;
        cycle(1, 8'h07, 8'h74, 0, 0);
        txOverflowClr = 1'b0;
        total++;
        if (txOverflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set_clr: got %b want 1", txOverflow);
        end
        cycle(0, 8'h00, 8'h00, 0, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_flush();
`ifdef SC_TX_PORT_FIFO_OVF_DETECT_EN
        test_overflow();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
